mem_writeback: RTL and testbench
================================

// Module: mem_writeback
// PURPOSE
//  Memory-access + write-back stage: the register-file *writer* facing iDecode's write port.
//  Takes an execute result, does the optional data-memory load/store, and returns write_data + rd.
//  Data memory access is multi-cycle, under a valid/ready handshake.
//  Sits after iExecute in datapath; wb_data drives iDecode write_data.
// PARAMETERS
//  WORD         64   datapath width (`WORD)
//  DMEM_DEPTH   128  data memory depth in doublewords (power of 2)
//  MEM_LATENCY  2    cycles spent in ACCESS per load/store (>=1)
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-high
//  in_valid     in   1        execute result present
//  in_ready     out  1        stage can accept (high only in IDLE)
//  alu_result   in   WORD     ALU result / byte address
//  store_data   in   WORD     read_data2 from decode, data for STUR
//  rd           in   5        destination register
//  mem_read     in   1        load
//  mem_write    in   1        store
//  mem_to_reg   in   1        wb source: 1=memory, 0=alu_result
//  reg_write    in   1        instruction writes rd
//  wb_valid     out  1        one-cycle pulse, write-back slot
//  wb_we        out  1        register write enable (qualified)
//  wb_rd        out  5        write-back register
//  wb_data      out  WORD     write_data to register file
//  align_fault  out  1        misaligned access pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): state=IDLE, in_ready=1, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, align_fault=0, counter=0.
//   Data memory contents are not cleared by reset. Reset mid-ACCESS aborts the access. A pending store whose
//   final ACCESS edge has not occurred is not written.
//  Accept: rising edge with in_valid && in_ready. Latch all inputs into holding registers.
//  FSM: IDLE -> ACCESS if accepted and (mem_read|mem_write); IDLE -> WB if accepted and neither is set.
//   ACCESS holds MEM_LATENCY cycles (counter 0..MEM_LATENCY-1), then goes to WB. WB -> IDLE unconditionally.
//  Latency from accept edge N: ALU op -> wb_valid high in the cycle after edge N+1.
//   Load/store -> wb_valid high in the cycle after edge N+MEM_LATENCY+1.
//  Throughput: one instruction per (2 + mem ? MEM_LATENCY : 0) cycles. in_ready=0 in ACCESS and WB.
//  Address: index = alu_result[log2(DMEM_DEPTH)+2:3]. Upper bits are ignored, so the index wraps modulo DMEM_DEPTH.
//  Store: memory written on the last ACCESS edge.
//  Load: data sampled on the last ACCESS edge into the WB data register.
//  mem_read && mem_write both set: read performed, write suppressed.
//  WB outputs are registered and stable for the whole WB cycle, then return to 0 (except wb_data, wb_rd, which hold).
//   wb_valid=1 for every instruction.
//   wb_we = reg_write && (rd != 31); XZR is never written.
//   wb_data = mem_to_reg ? loaded word : alu_result.
//  mem_to_reg=1 without mem_read: wb_data = 0.
//  in_valid while busy: ignored, not queued. The upstream stage holds until in_ready.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//   Any load/store with alu_result[2:0] != 0 skips ACCESS (IDLE -> WB) with no memory write.
//   wb_we is forced 0, and align_fault pulses 1 for the WB cycle.
//  MEM_ALIGN_CHECK_EN undefined: alu_result[2:0] ignored, align_fault tied 0.
// TESTING
//  1. Reset held 3 cycles, then released -> all outputs 0, in_ready=1.
//  2. ADD result 1234, rd=5, reg_write=1 -> one cycle later: wb_valid=1, wb_we=1, wb_rd=5, wb_data=1234.
//  3. STUR store_data=30 to alu_result=16, then LDUR from 16 to rd=9, mem_to_reg=1.
//     -> STUR wb_we=0; LDUR gives wb_data=30, wb_rd=9 at accept+MEM_LATENCY+1.
//  4. Store 0xAA at address 0, load from address DMEM_DEPTH*8 -> wrap: wb_data=0xAA.
//  5. ALU op with rd=31, reg_write=1, value 20 -> wb_valid=1, wb_we=0. in_valid during ACCESS is ignored.
//  6. Reset asserted mid-ACCESS of a store 77 to address 8 -> IDLE immediately; a later load from 8 is not 77.
//     With MEM_ALIGN_CHECK_EN: load from address 3 -> align_fault=1, wb_we=0.

Source files
------------

// File: rtl/mem_writeback.sv
// Memory-access / write-back stage: optional multi-cycle data-memory load/store, then one write-back pulse.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned loads/stores fault instead of touching memory.
module mem_writeback #(
    parameter int WORD        = 64,
    parameter int DMEM_DEPTH  = 128,
    parameter int MEM_LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] alu_result,
    input  logic [WORD-1:0] store_data,
    input  logic [4:0]      rd,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic            reg_write,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [WORD-1:0] wb_data,
    output logic            align_fault
);

    localparam int AW = $clog2(DMEM_DEPTH);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WB
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WORD-1:0] alu_q, alu_d;
    logic [WORD-1:0] sdata_q, sdata_d;
    logic [4:0]      rd_q, rd_d;
    logic            mr_q, mr_d;
    logic            mw_q, mw_d;
    logic            m2r_q, m2r_d;
    logic            rw_q, rw_d;
    logic            fault_q, fault_d;
    logic [WORD-1:0] load_q, load_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [WORD-1:0] wb_data_q, wb_data_d;
    logic            align_fault_q, align_fault_d;

    logic [WORD-1:0] dmem [DMEM_DEPTH];
    logic [AW-1:0]   mem_idx;
    logic            accept;
    logic            is_mem_in;
    logic            misalign_in;
    logic            last_access;
    logic            mem_we;

    assign in_ready    = (state_q == S_IDLE);
    assign accept      = in_valid && in_ready;
    assign is_mem_in   = mem_read | mem_write;
    // Upper address bits are dropped, so the doubleword index wraps modulo the depth.
    assign mem_idx     = alu_q[AW+2:3];
    assign last_access = (state_q == S_ACCESS) && (cnt_q == CW'(MEM_LATENCY - 1));
    // A load+store pair performs only the read.
    assign mem_we      = last_access && mw_q && !mr_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_in = is_mem_in && (alu_result[2:0] != 3'b000);
`else
    assign misalign_in = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_d         = alu_q;
        sdata_d       = sdata_q;
        rd_d          = rd_q;
        mr_d          = mr_q;
        mw_d          = mw_q;
        m2r_d         = m2r_q;
        rw_d          = rw_q;
        fault_d       = fault_q;
        load_d        = load_q;
        wb_valid_d    = 1'b0;
        wb_we_d       = 1'b0;
        align_fault_d = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_d   = alu_result;
                    sdata_d = store_data;
                    rd_d    = rd;
                    mr_d    = mem_read;
                    mw_d    = mem_write;
                    m2r_d   = mem_to_reg;
                    rw_d    = reg_write;
                    fault_d = misalign_in;
                    load_d  = '0;
                    cnt_d   = '0;
                    state_d = (is_mem_in && !misalign_in) ? S_ACCESS : S_WB;
                end
            end
            S_ACCESS: begin
                if (last_access) begin
                    if (mr_q) begin
                        load_d = dmem[mem_idx];
                    end
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                wb_valid_d    = 1'b1;
                wb_we_d       = rw_q && (rd_q != 5'd31) && !fault_q;
                align_fault_d = fault_q;
                wb_rd_d       = rd_q;
                // load_q stays zero unless a load actually completed.
                wb_data_d     = m2r_q ? load_q : alu_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            alu_q         <= '0;
            sdata_q       <= '0;
            rd_q          <= '0;
            mr_q          <= 1'b0;
            mw_q          <= 1'b0;
            m2r_q         <= 1'b0;
            rw_q          <= 1'b0;
            fault_q       <= 1'b0;
            load_q        <= '0;
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            align_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_q         <= alu_d;
            sdata_q       <= sdata_d;
            rd_q          <= rd_d;
            mr_q          <= mr_d;
            mw_q          <= mw_d;
            m2r_q         <= m2r_d;
            rw_q          <= rw_d;
            fault_q       <= fault_d;
            load_q        <= load_d;
            wb_valid_q    <= wb_valid_d;
            wb_we_q       <= wb_we_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            align_fault_q <= align_fault_d;
        end
    end

    // NOTE: the data array is deliberately not reset; it keeps contents across reset like a RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            dmem[mem_idx] <= sdata_q;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_we       = wb_we_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign align_fault = align_fault_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Self-checking bench for mem_writeback: directed scenarios plus random ops against a
// doubleword-array reference model; honours MEM_ALIGN_CHECK_EN when defined.
module tb_mem_writeback;

    localparam int WORD  = 64;
    localparam int DEPTH = 128;
    localparam int LAT   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [WORD-1:0] alu_result;
    logic [WORD-1:0] store_data;
    logic [4:0]      rd;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_write;
    logic            wb_valid;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [WORD-1:0] wb_data;
    logic            align_fault;

    mem_writeback #(
        .WORD       (WORD),
        .DMEM_DEPTH (DEPTH),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .store_data (store_data),
        .rd         (rd),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .align_fault(align_fault)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [63:0] model [DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        alu_result = '0;
        store_data = '0;
        rd         = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
        check({tag, "_wb_we"}, 64'(wb_we), 64'd0);
        check({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
        check({tag, "_wb_data"}, wb_data, 64'd0);
        check({tag, "_align_fault"}, 64'(align_fault), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    // One instruction from accept to its write-back pulse; expectations come from the model.
    task automatic issue(input string tag, input logic [63:0] alu, input logic [63:0] sd,
                         input logic [4:0] r, input logic mr, input logic mw,
                         input logic m2r, input logic rw, input bit spam);
        logic        mem_op;
        logic        fault;
        logic        exp_we;
        logic [63:0] exp_data;
        int          k;
        int          idx;
        mem_op = mr | mw;
        fault  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        fault  = mem_op && (alu[2:0] != 3'b000);
`endif
        idx      = int'((alu >> 3) % 64'(DEPTH));
        k        = (mem_op && !fault) ? LAT + 1 : 1;
        exp_we   = rw && (r != 5'd31) && !fault;
        exp_data = !m2r ? alu : ((mr && !fault) ? model[idx] : 64'd0);
        if (mw && !mr && !fault) model[idx] = sd;

        @(negedge clk);
        check({tag, "_ready_idle"}, 64'(in_ready), 64'd1);
        check({tag, "_no_wb_idle"}, 64'(wb_valid), 64'd0);
        in_valid   = 1'b1;
        alu_result = alu;
        store_data = sd;
        rd         = r;
        mem_read   = mr;
        mem_write  = mw;
        mem_to_reg = m2r;
        reg_write  = rw;
        @(posedge clk);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (spam) begin
                    // Busy-time request that must be ignored: a store the model never sees.
                    in_valid   = 1'b1;
                    alu_result = {$urandom, $urandom};
                    store_data = {$urandom, $urandom};
                    rd         = 5'($urandom_range(0, 30));
                    mem_read   = 1'b0;
                    mem_write  = 1'b1;
                    mem_to_reg = 1'b0;
                    reg_write  = 1'b1;
                end else begin
                    idle_inputs();
                end
            end
            check({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
            check({tag, "_busy_no_wb"}, 64'(wb_valid), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        idle_inputs();
        check({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
        check({tag, "_wb_we"}, 64'(wb_we), 64'(exp_we));
        check({tag, "_wb_rd"}, 64'(wb_rd), 64'(r));
        check({tag, "_wb_data"}, wb_data, exp_data);
        check({tag, "_align_fault"}, 64'(align_fault), 64'(fault));
        check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] v;
        logic [4:0]  r;
        int          kind;

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset_held");
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_released");

        // Give every location a known value so every later load has a defined expectation.
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == 1) ? 64'd55 : {$urandom, $urandom};
            issue("init", 64'(i) * 64'd8, v, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        issue("add", 64'd1234, 64'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        issue("stur16", 64'd16, 64'd30, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("ldur16", 64'd16, 64'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        issue("stur0", 64'd0, 64'hAA, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("ld_wrap", 64'(DEPTH) * 64'd8, 64'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        issue("xzr", 64'd20, 64'd0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        issue("ld_spam", 64'd24, 64'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        issue("rd_and_wr", 64'd40, 64'd999, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        issue("ld40", 64'd40, 64'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        issue("m2r_noread", 64'd100, 64'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset in the first ACCESS cycle of a store: it must never reach memory.
        @(negedge clk);
        in_valid   = 1'b1;
        alu_result = 64'd8;
        store_data = 64'd77;
        mem_write  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        check("abort_busy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1;
        check("abort_ready", 64'(in_ready), 64'd1);
        check("abort_wb_valid", 64'(wb_valid), 64'd0);
        check("abort_wb_data", wb_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        issue("ld8_after_abort", 64'd8, 64'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        issue("ld_mis3", 64'd3, 64'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        issue("st_mis13", 64'd13, 64'd1234, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        issue("ld8_after_mis", 64'd8, 64'd0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        for (int n = 0; n < 120; n++) begin
            kind = int'($urandom_range(0, 4));
            a    = {$urandom, $urandom};
            if (kind != 0 && $urandom_range(0, 3) != 0) a[2:0] = 3'b000;
            v = {$urandom, $urandom};
            r = 5'($urandom_range(0, 31));
            case (kind)
                0:       issue("rnd_alu", a, v, r, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                1:       issue("rnd_st", a, v, r, 1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
                2:       issue("rnd_ld", a, v, r, 1'b1, 1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
                3:       issue("rnd_ldst", a, v, r, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
                default: issue("rnd_m2r", a, v, r, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            endcase
        end

        // Re-read a spread of locations to catch any stray or missing writes.
        for (int i = 0; i < DEPTH; i += 5) begin
            issue("sweep", 64'(i) * 64'd8, 64'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
